// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and constants for the multi-channel clock divider.
//   phase_e             - per-channel phase state (IDLE / LOW / HIGH)
//   CLKDIV_DEFAULT_HALF - half-period loaded into every channel at reset
//   clkdiv_idx_w()      - width of a channel index, never less than 1 bit
package clkdiv_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_LOW  = 2'd1,
    PH_HIGH = 2'd2
  } phase_e;

  localparam int CLKDIV_DEFAULT_HALF = 500;

  function automatic int clkdiv_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel (half-period register, up-counter,
// IDLE/LOW/HIGH phase FSM and optional rising-edge tick).
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   en_i         run enable; low freezes count, phase and output level
//   load_i       program strobe for this channel (already decoded)
//   load_half_i  new half-period; 0 parks the channel in IDLE
//   clk_out_o    divided square wave, high exactly in HIGH
//   tick_o       one-cycle pulse on each clk_out_o rise
// Build option: CLKDIV_TICK_EN builds the tick register; otherwise tick_o is 0.
//
// state   | meaning
// PH_IDLE | half = 0, output held low, count held at 0
// PH_LOW  | output low, counting up to half-1
// PH_HIGH | output high, counting up to half-1
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_half_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [WIDTH-1:0] DEF_HALF  = WIDTH'(DEFAULT_HALF);
  localparam phase_e           DEF_PHASE = (DEFAULT_HALF == 0) ? PH_IDLE : PH_LOW;

  phase_e           state_q, state_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic [WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DEF_PHASE;
      half_q  <= DEF_HALF;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    count_d = count_q;
    if (load_i) begin
      half_d  = load_half_i;
      count_d = '0;
      state_d = (load_half_i == '0) ? PH_IDLE : PH_LOW;
    end else begin
      unique case (state_q)
        PH_IDLE: count_d = '0;
        PH_LOW, PH_HIGH: begin
          // half_q is nonzero in LOW/HIGH, so half_q-1 cannot wrap.
          // '>=' also recovers cleanly if count ever exceeds the limit.
          if (en_i) begin
            if (count_q >= half_q - WIDTH'(1)) begin
              count_d = '0;
              state_d = (state_q == PH_LOW) ? PH_HIGH : PH_LOW;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        default: begin
          count_d = '0;
          state_d = (half_q == '0) ? PH_IDLE : PH_LOW;
        end
      endcase
    end
  end

  assign clk_out_o = (state_q == PH_HIGH);

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  // Registered alongside the state, so the pulse lines up with the first
  // cycle in which clk_out_o reads high.
  assign tick_d = (state_q == PH_LOW) && (state_d == PH_HIGH);

  always_ff @(posedge clk_i) begin
    if (rst_i) tick_q <= 1'b0;
    else       tick_q <= tick_d;
  end

  assign tick_o = tick_q;
`else
  assign tick_o = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: N-channel programmable clock divider.
// Ports:
//   CLK100MHZ  system clock, rising edge
//   rst        synchronous active-high reset
//   en         per-channel run enable
//   load       one-cycle program strobe
//   load_ch    target channel; indices >= CHANNELS are ignored
//   load_half  new half-period for the target channel
//   load_ack   one-cycle pulse the cycle after an accepted load
//   clk_out    per-channel divided square wave
//   tick       per-channel rise pulse (zero unless CLKDIV_TICK_EN is defined)
// Build option: CLKDIV_TICK_EN enables the tick registers in each channel.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 16,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic                                CLK100MHZ,
  input  logic                                rst,
  input  logic [CHANNELS-1:0]                 en,
  input  logic                                load,
  input  logic [clkdiv_idx_w(CHANNELS)-1:0]   load_ch,
  input  logic [WIDTH-1:0]                    load_half,
  output logic                                load_ack,
  output logic [CHANNELS-1:0]                 clk_out,
  output logic [CHANNELS-1:0]                 tick
);

  localparam int IDXW = clkdiv_idx_w(CHANNELS);
  // One extra bit so CHANNELS itself is representable (e.g. 16 with IDXW=4).
  localparam logic [IDXW:0] CH_LIM = (IDXW + 1)'(CHANNELS);

  logic load_ok;
  logic load_ack_q, load_ack_d;

  assign load_ok    = load && ({1'b0, load_ch} < CH_LIM);
  assign load_ack_d = load_ok;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) load_ack_q <= 1'b0;
    else     load_ack_q <= load_ack_d;
  end

  assign load_ack = load_ack_q;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic load_sel;
    assign load_sel = load_ok && (load_ch == IDXW'(gi));

    clkdiv_channel #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_i       (CLK100MHZ),
      .rst_i       (rst),
      .en_i        (en[gi]),
      .load_i      (load_sel),
      .load_half_i (load_half),
      .clk_out_o   (clk_out[gi]),
      .tick_o      (tick[gi])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi with five channels, so that indices 5..7 exist on
// the 3-bit load_ch port and can be rejected.
module tb_clkdiv_multi;

  localparam int NCH = 5;
  localparam int DEFH = 500;
`ifdef CLKDIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  en;
  logic            load;
  logic [2:0]      load_ch;
  logic [15:0]     load_half;
  logic            load_ack;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  tick;

  always #5 clk = ~clk;

  clkdiv_multi #(.CHANNELS(NCH), .WIDTH(16), .DEFAULT_HALF(DEFH)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_ch   (load_ch),
    .load_half (load_half),
    .load_ack  (load_ack),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  typedef struct packed {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tk;
    logic           ack;
  } exp_t;

  typedef struct {
    int ch;
    int h;
    int exp_rise;
    int exp_high;
    int exp_low;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: each channel is a position p in [0, 2H); output is
  // high for p >= H.
  int   m_half [NCH];
  int   m_p    [NCH];
  logic m_tick [NCH];
  logic m_ack;

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_half[i] = DEFH; m_p[i] = 0; m_tick[i] = 1'b0;
      end
      m_ack = 1'b0;
    end else begin
      m_ack = load && (int'(load_ch) < NCH);
      for (int i = 0; i < NCH; i++) begin
        if (load && int'(load_ch) == i) begin
          m_half[i] = int'(load_half); m_p[i] = 0; m_tick[i] = 1'b0;
        end else if (en[i] && m_half[i] != 0) begin
          m_p[i]    = (m_p[i] + 1) % (2 * m_half[i]);
          m_tick[i] = TICK_ON && (m_p[i] == m_half[i]);
        end else begin
          m_tick[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    exp_t e, got;
    model_edge();
    for (int i = 0; i < NCH; i++) begin
      e.clk[i] = (m_half[i] != 0) && (m_p[i] >= m_half[i]);
      e.tk[i]  = m_tick[i];
    end
    e.ack = m_ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got.clk = clk_out; got.tk = tick; got.ack = load_ack;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty cycle=%0d", cyc);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL sb cycle=%0d clk_out=%b tick=%b ack=%b expected clk_out=%b tick=%b ack=%b",
                 cyc, got.clk, got.tk, got.ack, e.clk, e.tk, e.ack);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Steps until clk_out[ch] reads lvl; returns the number of steps taken.
  task automatic wait_level(input int ch, input logic lvl, input int limit, output int n);
    n = 0;
    while (clk_out[ch] !== lvl && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic do_load(input int ch, input int h);
    load = 1'b1; load_ch = 3'(ch); load_half = 16'(h);
    step();
    load = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ones, total;

    vecs[0] = '{ch: 2, h: 1, exp_rise: 1, exp_high: 1, exp_low: 1};
    vecs[1] = '{ch: 3, h: 7, exp_rise: 7, exp_high: 7, exp_low: 7};
    vecs[2] = '{ch: 4, h: 2, exp_rise: 2, exp_high: 2, exp_low: 2};
    vecs[3] = '{ch: 1, h: 5, exp_rise: 5, exp_high: 5, exp_low: 5};

    rst = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_half = '0;
    step();
    step();
    check_int("reset_clk_out", int'(clk_out), 0);
    check_int("reset_ack", int'(load_ack), 0);

    // Default half-period from reset.
    rst = 1'b0; en = '1;
    wait_level(0, 1'b1, 600, n); check_int("def_rise", n, 500);
    wait_level(0, 1'b0, 600, n); check_int("def_high", n, 500);
    wait_level(0, 1'b1, 600, n); check_int("def_low", n, 500);

    // H=1 on ch2: ack next cycle, toggles every cycle.
    do_load(2, 1);
    check_int("h1_ack", int'(load_ack), 1);
    check_int("h1_clk0", int'(clk_out[2]), 0);
    step();
    check_int("h1_ack_drop", int'(load_ack), 0);
    check_int("h1_clk1", int'(clk_out[2]), 1);
    step();
    check_int("h1_clk2", int'(clk_out[2]), 0);

    // Back-to-back loads keep load_ack high.
    load = 1'b1; load_ch = 3'd3; load_half = 16'd4;
    step();
    check_int("b2b_ack1", int'(load_ack), 1);
    load_ch = 3'd4; load_half = 16'd6;
    step();
    check_int("b2b_ack2", int'(load_ack), 1);
    load = 1'b0;
    step();
    check_int("b2b_ack_end", int'(load_ack), 0);

    // Table of reloads: rise latency and both half-periods.
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].ch, vecs[v].h);
      wait_level(vecs[v].ch, 1'b1, 100, n); check_int($sformatf("vec%0d_rise", v), n, vecs[v].exp_rise);
      wait_level(vecs[v].ch, 1'b0, 100, n); check_int($sformatf("vec%0d_high", v), n, vecs[v].exp_high);
      wait_level(vecs[v].ch, 1'b1, 100, n); check_int($sformatf("vec%0d_low", v), n, vecs[v].exp_low);
    end

    // H=0 parks ch1 low; reload H=3 restarts it.
    do_load(1, 0);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (clk_out[1]) ones++;
    end
    check_int("h0_stays_low", ones, 0);
    do_load(1, 3);
    wait_level(1, 1'b1, 100, n); check_int("h3_rise", n, 3);
    wait_level(1, 1'b0, 100, n); check_int("h3_high", n, 3);
    wait_level(1, 1'b1, 100, n); check_int("h3_low", n, 3);

    // Out-of-range channel indices are ignored.
    do_load(5, 2);
    check_int("bad_ch5_ack", int'(load_ack), 0);
    do_load(7, 0);
    check_int("bad_ch7_ack", int'(load_ack), 0);
    for (int i = 0; i < 10; i++) step();

    // Freeze ch0 for 37 cycles in the middle of HIGH.
    do_load(0, 10);
    wait_level(0, 1'b1, 100, n); check_int("frz_rise", n, 10);
    for (int i = 0; i < 3; i++) step();
    en[0] = 1'b0;
    for (int i = 0; i < 37; i++) step();
    check_int("frz_held_high", int'(clk_out[0]), 1);
    en[0] = 1'b1;
    wait_level(0, 1'b0, 100, n);
    total = 3 + 37 + n;
    check_int("frz_high_len", total, 47);

    // Reset together with a load mid-period.
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; load = 1'b1; load_ch = 3'd2; load_half = 16'd9;
    step();
    rst = 1'b0; load = 1'b0;
    check_int("rst_clk_out", int'(clk_out), 0);
    check_int("rst_tick", int'(tick), 0);
    check_int("rst_ack", int'(load_ack), 0);
    wait_level(2, 1'b1, 600, n); check_int("rst_half_default", n, 500);

    check_int("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
